// File: rtl/pat_seq_pkg.sv
// Shared definitions for the pattern-buffer program sequencer: condition codes,
// the selected-operation encoding and the condition evaluator.
package pat_seq_pkg;

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_Z      = 2'b01;
    localparam logic [1:0] COND_NZ     = 2'b10;
    localparam logic [1:0] COND_NEG    = 2'b11;

    typedef enum logic [2:0] {
        SEL_INC,
        SEL_BF,
        SEL_BB,
        SEL_CALL,
        SEL_RET
    } sel_e;

    function automatic logic cond_eval(input logic [1:0] cond, input logic zero,
                                       input logic neg);
        logic ok;
        unique case (cond)
            COND_ALWAYS: ok = 1'b1;
            COND_Z:      ok = zero;
            COND_NZ:     ok = ~zero;
            COND_NEG:    ok = neg;
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/pat_call_stack.sv
// Parametrised LIFO holding return addresses. No error handling: a push when
// full or a pop when empty is ignored, the caller is expected to gate them.
module pat_call_stack #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned WIDTH     = 10,
    parameter int unsigned PTR_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic [WIDTH-1:0]     i_wdata,
    output logic [WIDTH-1:0]     o_top,
    output logic [PTR_WIDTH:0]   o_depth,
    output logic                 o_full,
    output logic                 o_empty
);

    localparam logic [PTR_WIDTH:0] CntOne  = (PTR_WIDTH + 1)'(1);
    localparam logic [PTR_WIDTH:0] CntFull = (PTR_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [PTR_WIDTH:0]   r_count;
    logic [PTR_WIDTH:0]   w_count_m1;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign o_full     = (r_count == CntFull);
    assign o_empty    = (r_count == '0);
    assign w_do_push  = i_push & ~o_full;
    assign w_do_pop   = i_pop & ~o_empty & ~i_push;
    assign w_count_m1 = r_count - CntOne;
    assign o_top      = r_mem[w_count_m1[PTR_WIDTH-1:0]];
    assign o_depth    = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + CntOne;
        end else if (w_do_pop) begin
            r_count <= w_count_m1;
        end
    end

    // Storage is not reset; contents are meaningless until pushed.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_count[PTR_WIDTH-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/pat_sequencer.sv
// Program sequencer: owns the PC and call/return stack, resolving one-hot
// branch/call/return strobes with condition codes into the next address.
module pat_sequencer
    import pat_seq_pkg::*;
#(
    parameter int unsigned I_ADR_WIDTH     = 10,
    parameter int unsigned OFFSET_WIDTH    = 8,
    parameter int unsigned STACK_DEPTH     = 8,
    parameter int unsigned STACK_PTR_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       op_bf,
    input  logic                       op_bb,
    input  logic                       op_call,
    input  logic                       op_ret,
    input  logic [1:0]                 condition,
    input  logic                       flag_zero,
    input  logic                       flag_neg,
    input  logic [OFFSET_WIDTH-1:0]    offset,
    input  logic                       clr_err,
    output logic [I_ADR_WIDTH-1:0]     pc,
    output logic [STACK_PTR_WIDTH:0]   depth,
    output logic                       taken,
    output logic                       overflow,
    output logic                       underflow
);

    logic [I_ADR_WIDTH-1:0] r_pc;
    logic                   r_taken;
    logic                   r_overflow;
    logic                   r_underflow;

    logic                   w_cond_ok;
    sel_e                   w_sel;
    logic                   w_ovf_evt;
    logic                   w_udf_evt;
    logic                   w_full;
    logic                   w_empty;
    logic [I_ADR_WIDTH-1:0] w_top;
    logic [I_ADR_WIDTH-1:0] w_offset_ext;
    logic [I_ADR_WIDTH-1:0] w_pc_inc;
    logic [I_ADR_WIDTH-1:0] w_pc_next;

    assign w_cond_ok    = cond_eval(condition, flag_zero, flag_neg);
    assign w_offset_ext = I_ADR_WIDTH'(offset);
    assign w_pc_inc     = r_pc + I_ADR_WIDTH'(1);

    // Only the highest-priority strobe is considered; a false condition or a
    // stack error on it falls back to a plain increment.
    always_comb begin
        w_sel     = SEL_INC;
        w_ovf_evt = 1'b0;
        w_udf_evt = 1'b0;
        if (!stall) begin
            if (op_ret) begin
                if (w_cond_ok) begin
                    if (w_empty) w_udf_evt = 1'b1;
                    else         w_sel     = SEL_RET;
                end
            end else if (op_call) begin
                if (w_cond_ok) begin
                    if (w_full) w_ovf_evt = 1'b1;
                    else        w_sel     = SEL_CALL;
                end
            end else if (op_bf) begin
                if (w_cond_ok) w_sel = SEL_BF;
            end else if (op_bb) begin
                if (w_cond_ok) w_sel = SEL_BB;
            end
        end
    end

    always_comb begin
        w_pc_next = w_pc_inc;
        unique case (w_sel)
            SEL_RET:          w_pc_next = w_top;
            SEL_CALL, SEL_BF: w_pc_next = r_pc + w_offset_ext;
            SEL_BB:           w_pc_next = r_pc - w_offset_ext;
            default:          w_pc_next = w_pc_inc;
        endcase
    end

    pat_call_stack #(
        .DEPTH     (STACK_DEPTH),
        .WIDTH     (I_ADR_WIDTH),
        .PTR_WIDTH (STACK_PTR_WIDTH)
    ) u_stack (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_sel == SEL_CALL),
        .i_pop   (w_sel == SEL_RET),
        .i_wdata (w_pc_inc),
        .o_top   (w_top),
        .o_depth (depth),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc        <= '0;
            r_taken     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (stall) begin
                r_taken <= 1'b0;
            end else begin
                r_pc    <= w_pc_next;
                r_taken <= (w_sel != SEL_INC);
            end
            // A new error on the same edge as a clear wins.
            if (w_ovf_evt)    r_overflow  <= 1'b1;
            else if (clr_err) r_overflow  <= 1'b0;
            if (w_udf_evt)    r_underflow <= 1'b1;
            else if (clr_err) r_underflow <= 1'b0;
        end
    end

    assign pc        = r_pc;
    assign taken     = r_taken;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_pat_sequencer.sv
// Directed bench for pat_sequencer: hand-computed PC/stack/flag expectations
// checked with immediate assertions after each clock edge.
module tb_pat_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall;
    logic       op_bf;
    logic       op_bb;
    logic       op_call;
    logic       op_ret;
    logic [1:0] condition;
    logic       flag_zero;
    logic       flag_neg;
    logic [7:0] offset;
    logic       clr_err;
    logic [9:0] pc;
    logic [3:0] depth;
    logic       taken;
    logic       overflow;
    logic       underflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pat_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .op_bf     (op_bf),
        .op_bb     (op_bb),
        .op_call   (op_call),
        .op_ret    (op_ret),
        .condition (condition),
        .flag_zero (flag_zero),
        .flag_neg  (flag_neg),
        .offset    (offset),
        .clr_err   (clr_err),
        .pc        (pc),
        .depth     (depth),
        .taken     (taken),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int e_pc, input int e_depth,
                             input int e_taken);
        chk({tag, ".pc"}, 32'(pc), 32'(e_pc));
        chk({tag, ".depth"}, 32'(depth), 32'(e_depth));
        chk({tag, ".taken"}, 32'(taken), 32'(e_taken));
    endtask

    task automatic drive(input logic ret, input logic call, input logic bf, input logic bb,
                         input logic [1:0] cond, input logic [7:0] off);
        op_ret    = ret;
        op_call   = call;
        op_bf     = bf;
        op_bb     = bb;
        condition = cond;
        offset    = off;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
        clr_err = 1'b0;
        stall   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        flag_zero = 1'b0;
        flag_neg  = 1'b0;
        idle();
        tick();
        tick();
        chk_state("reset", 0, 0, 0);
        chk("reset.ovf", 32'(overflow), 0);
        chk("reset.udf", 32'(underflow), 0);

        reset = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_state($sformatf("idle%0d", i), i, 0, 0);
        end
        for (int i = 6; i <= 10; i++) tick();
        chk("pc_at_10", 32'(pc), 10);

        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 8'd20);
        tick();
        chk_state("bf20", 30, 0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 8'd5);
        tick();
        chk_state("bb5", 25, 0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 8'd25);
        tick();
        chk_state("bb_to0", 0, 0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 8'd1);
        tick();
        chk_state("bb_wrap", 1023, 0, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 8'd101);
        tick();
        chk_state("bf_wrap", 100, 0, 1);

        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 8'd50);
        tick();
        chk_state("call50", 150, 1, 1);
        idle();
        tick();
        tick();
        chk_state("idle2", 152, 1, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
        tick();
        chk_state("ret", 101, 0, 1);

        // Nested calls from pc=101 with offset 10 push 102,112,...,172.
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 8'd10);
            tick();
            chk_state($sformatf("ncall%0d", k), 111 + 10 * k, k + 1, 1);
        end
        tick();
        chk_state("call_full", 182, 8, 0);
        chk("ovf_set", 32'(overflow), 1);
        idle();
        clr_err = 1'b1;
        tick();
        chk("ovf_clr", 32'(overflow), 0);
        chk("clr_pc", 32'(pc), 183);
        clr_err = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0);
            tick();
            chk_state($sformatf("nret%0d", k), 102 + 10 * k, k, 1);
        end

        tick();
        chk_state("ret_empty", 103, 0, 0);
        chk("udf_set", 32'(underflow), 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 8'd20);
        flag_zero = 1'b0;
        tick();
        chk_state("bf_z_false", 104, 0, 0);
        flag_zero = 1'b1;
        tick();
        chk_state("bf_z_true", 124, 0, 1);
        chk("udf_sticky", 32'(underflow), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 8'd4);
        flag_neg = 1'b1;
        tick();
        chk_state("bb_neg", 120, 0, 1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 8'd30);
        tick();
        chk_state("call_nz_false", 121, 0, 0);
        flag_zero = 1'b0;
        flag_neg  = 1'b0;
        idle();
        clr_err = 1'b1;
        tick();
        chk_state("clr_udf", 122, 0, 0);
        chk("udf_clr", 32'(underflow), 0);
        clr_err = 1'b0;

        drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 8'd8);
        tick();
        chk_state("prio_call_bf", 130, 1, 1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'd8);
        tick();
        chk_state("prio_ret_call", 123, 0, 1);

        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 8'd1);
            tick();
        end
        chk_state("call3", 126, 3, 1);
        stall = 1'b1;
        tick();
        chk_state("stall", 126, 3, 0);
        tick();
        chk_state("stall2", 126, 3, 0);
        #2;
        reset = 1'b0;
        #1;
        chk_state("async_rst", 0, 0, 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_udf", 32'(underflow), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
